// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage: valid/ready handshake with a two-entry skid buffer,
// synchronous flush, bubble control gating, forwarding tap and stall counter.
//
// state   | meaning
// S_EMPTY | no entry held, outputs invalid
// S_ONE   | MAIN holds the head entry
// S_TWO   | MAIN holds the head, SKID holds the next entry, in_ready low
module exmem_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_wb,
    input  logic [1:0]      in_m,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_op2,
    input  logic [REGW-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_reg_write,
    output logic            out_mem_to_reg,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [XLEN-1:0] out_addr,
    output logic [XLEN-1:0] out_wdata,
    output logic [REGW-1:0] out_rd,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [CNTW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]      main_wb, main_m, skid_wb, skid_m;
    logic [XLEN-1:0] main_alu, main_op2, skid_alu, skid_op2;
    logic [REGW-1:0] main_rd, skid_rd;
    logic            in_ready_q;
    logic            accept, pop;
    logic            load_main_in, load_main_skid, load_skid;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt    = S_ONE;
                    load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = S_TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_nxt      = S_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        // Flush drops the incoming transfer; MAIN keeps its data so outputs hold.
        if (flush) begin
            state_nxt      = S_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_wb  <= '0;
            main_m   <= '0;
            main_alu <= '0;
            main_op2 <= '0;
            main_rd  <= '0;
        end else if (load_main_in) begin
            main_wb  <= in_wb;
            main_m   <= in_m;
            main_alu <= in_alu;
            main_op2 <= in_op2;
            main_rd  <= in_rd;
        end else if (load_main_skid) begin
            main_wb  <= skid_wb;
            main_m   <= skid_m;
            main_alu <= skid_alu;
            main_op2 <= skid_op2;
            main_rd  <= skid_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_wb  <= '0;
            skid_m   <= '0;
            skid_alu <= '0;
            skid_op2 <= '0;
            skid_rd  <= '0;
        end else if (load_skid) begin
            skid_wb  <= in_wb;
            skid_m   <= in_m;
            skid_alu <= in_alu;
            skid_op2 <= in_op2;
            skid_rd  <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (state != S_EMPTY);
    assign out_reg_write  = out_valid & main_wb[1];
    assign out_mem_to_reg = out_valid & main_wb[0];
    assign out_mem_read   = out_valid & main_m[1];
    assign out_mem_write  = out_valid & main_m[0];
    assign out_addr       = main_alu;
    assign out_wdata      = main_op2;
    assign out_rd         = main_rd;
    assign fwd_valid      = out_valid & out_reg_write & (out_rd != '0);
    assign fwd_rd         = out_rd;
    assign fwd_data       = out_addr;

endmodule

// File: tb/tb_exmem_stage.sv
// Bench for exmem_stage: directed steps plus random traffic, checked against
// a queue-based model of the stage's FIFO behaviour.
module tb_exmem_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef struct packed {
        logic [1:0]      wb;
        logic [1:0]      m;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] op2;
        logic [REGW-1:0] rd;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [1:0]      in_wb = '0;
    logic [1:0]      in_m = '0;
    logic [XLEN-1:0] in_alu = '0;
    logic [XLEN-1:0] in_op2 = '0;
    logic [REGW-1:0] in_rd = '0;

    logic            in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_read, out_mem_write;
    logic [XLEN-1:0] out_addr, out_wdata, fwd_data;
    logic [REGW-1:0] out_rd, fwd_rd;
    logic            fwd_valid;
    logic [15:0]     stall_cnt;

    logic            s_in_ready, s_out_valid, s_rw, s_m2r, s_mr, s_mw, s_fwd_valid;
    logic [XLEN-1:0] s_addr, s_wdata, s_fwd_data;
    logic [REGW-1:0] s_rd, s_fwd_rd;
    logic [3:0]      s_stall_cnt;

    exmem_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb(in_wb), .in_m(in_m), .in_alu(in_alu), .in_op2(in_op2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_rd(out_rd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    exmem_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_wb(in_wb), .in_m(in_m), .in_alu(in_alu), .in_op2(in_op2), .in_rd(in_rd),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_reg_write(s_rw), .out_mem_to_reg(s_m2r),
        .out_mem_read(s_mr), .out_mem_write(s_mw),
        .out_addr(s_addr), .out_wdata(s_wdata), .out_rd(s_rd),
        .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
        .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    ent_t q[$];
    ent_t last = '0;
    bit   rdy_m = 1'b1;
    int   cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit v;
        int e16, e4;
        v   = (q.size() > 0);
        e16 = (cnt > 65535) ? 65535 : cnt;
        e4  = (cnt > 15) ? 15 : cnt;
        chk("out_valid",      64'(out_valid),      64'(v));
        chk("in_ready",       64'(in_ready),       64'(rdy_m));
        chk("out_addr",       64'(out_addr),       64'(last.alu));
        chk("out_wdata",      64'(out_wdata),      64'(last.op2));
        chk("out_rd",         64'(out_rd),         64'(last.rd));
        chk("out_reg_write",  64'(out_reg_write),  64'(v && last.wb[1]));
        chk("out_mem_to_reg", 64'(out_mem_to_reg), 64'(v && last.wb[0]));
        chk("out_mem_read",   64'(out_mem_read),   64'(v && last.m[1]));
        chk("out_mem_write",  64'(out_mem_write),  64'(v && last.m[0]));
        chk("fwd_valid",      64'(fwd_valid),      64'(v && last.wb[1] && (last.rd != 0)));
        chk("fwd_rd",         64'(fwd_rd),         64'(last.rd));
        chk("fwd_data",       64'(fwd_data),       64'(last.alu));
        chk("stall_cnt",      64'(stall_cnt),      64'(e16));
        chk("stall_cnt_sat",  64'(s_stall_cnt),    64'(e4));
        chk("sat_out_valid",  64'(s_out_valid),    64'(v));
    endtask

    // Advance one clock: update the model from the pre-edge inputs, then
    // compare at the following falling edge.
    task automatic cycle();
        bit   acc, pp;
        ent_t cur;
        cur = '{wb: in_wb, m: in_m, alu: in_alu, op2: in_op2, rd: in_rd};
        acc = in_valid && rdy_m;
        pp  = (q.size() > 0) && out_ready;
        if (q.size() > 0 && !out_ready) cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        if (q.size() > 0) last = q[0];
        rdy_m = (q.size() < 2);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] alu, input logic [REGW-1:0] rd,
                         input logic [1:0] wb, input logic [1:0] m);
        in_valid = v;
        in_alu   = alu;
        in_op2   = ~alu;
        in_rd    = rd;
        in_wb    = wb;
        in_m     = m;
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        q.delete();
        last  = '0;
        rdy_m = 1'b1;
        cnt   = 0;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held with in_valid high
        drive(1'b1, 32'hdead_beef, 5'd7, 2'b11, 2'b11);
        out_ready = 1'b1;
        #22;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // First transfer after reset
        drive(1'b1, 32'h0000_1000, 5'd5, 2'b10, 2'b00);
        cycle();
        chk("first_addr", 64'(out_addr), 64'h1000);
        chk("first_fwd",  64'(fwd_valid), 64'd1);
        drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
        cycle();

        // Streaming 8 entries
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 5'(i), 2'b10, 2'b00);
            cycle();
            chk("stream_addr", 64'(out_addr), 64'(i));
        end
        drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
        cycle();
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure: A, B fill the stage, C waits at EX
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_00a0, 5'd10, 2'b10, 2'b10);
        cycle();
        drive(1'b1, 32'h0000_00b0, 5'd11, 2'b11, 2'b10);
        cycle();
        drive(1'b1, 32'h0000_00c0, 5'd12, 2'b10, 2'b01);
        cycle();
        cycle();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head",     64'(out_addr), 64'h00a0);
        out_ready = 1'b1;
        cycle();
        chk("bp_second", 64'(out_addr), 64'h00b0);
        cycle();
        chk("bp_third", 64'(out_addr), 64'h00c0);
        drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
        cycle();
        cycle();

        // Flush from full with D presented
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0a00, 5'd3, 2'b10, 2'b00);
        cycle();
        drive(1'b1, 32'h0000_0b00, 5'd4, 2'b10, 2'b01);
        cycle();
        drive(1'b1, 32'h0000_0d00, 5'd6, 2'b11, 2'b11);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
        out_ready = 1'b1;
        cycle();
        cycle();

        // Control decode, rd 0 forwarding, bubbles
        drive(1'b1, 32'h0000_0100, 5'd9, 2'b00, 2'b01);
        cycle();
        chk("m_write", 64'(out_mem_write), 64'd1);
        chk("m_read",  64'(out_mem_read),  64'd0);
        drive(1'b1, 32'h0000_0200, 5'd0, 2'b10, 2'b00);
        cycle();
        chk("rd0_fwd", 64'(fwd_valid), 64'd0);
        drive(1'b0, 32'h0, 5'd0, 2'b11, 2'b11);
        cycle();
        cycle();

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0300, 5'd1, 2'b11, 2'b11);
        cycle();
        cycle();
        do_reset();

        // Saturation of the 4-bit counter
        drive(1'b1, 32'h0000_0400, 5'd2, 2'b10, 2'b00);
        cycle();
        drive(1'b0, 32'h0, 5'd0, 2'b00, 2'b00);
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_15",  64'(s_stall_cnt), 64'd15);
        chk("sat_wide", 64'(stall_cnt), 64'd20);
        out_ready = 1'b1;
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(15) == 0);
            in_wb     = 2'($urandom);
            in_m      = 2'($urandom);
            in_alu    = $urandom;
            in_op2    = $urandom;
            in_rd     = 5'($urandom);
            cycle();
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
